eq_band_scheduler: RTL and testbench
====================================

# eq_band_scheduler

Control sequencer for the time-multiplexed 8-band FIR equalizer datapath. For each accepted input audio sample it writes the sample into the shared 64-entry circular delay line. It then drives one shared MAC through all 64 taps of each band in turn, generating coefficient and delay-line addresses, MAC clear/enable strobes and per-band completion strobes. It sits between the audio input handshake and the delay-line RAM, coefficient ROM and MAC/accumulator.

## Interface
- NUM_BANDS, 8, number of bands processed per sample (band_sel width fixed at 3 bits)
- TAP_BITS, 6, log2 of taps per band and of delay-line depth (64)
- DATA_W, 16, audio sample width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- sample_in  in  DATA_W  input audio sample
- sample_valid  in  1  sample_in valid
- sample_ready  out  1  block can accept a sample
- wr_en  out  1  delay-line write strobe
- wr_ptr  out  TAP_BITS  delay-line write address (newest sample)
- wr_data  out  DATA_W  sample captured at handshake
- tap_idx  out  TAP_BITS  coefficient tap index
- smp_addr  out  TAP_BITS  delay-line read address, (wr_ptr − tap_idx) mod 64
- band_sel  out  3  band currently processed or completed
- mac_clr  out  1  load accumulator with product instead of adding (first tap)
- mac_en  out  1  MAC active this cycle
- band_done  out  1  one-cycle strobe: accumulator holds final result for band_sel
- busy  out  1  high from handshake+1 until return to IDLE
- overrun  out  1  sticky dropped-sample flag (see Configuration)

## Operation
- FSM states: IDLE, WRITE, RUN, DRAIN. All outputs registered except smp_addr (combinational from wr_ptr, tap_idx).
- Reset values: state IDLE, sample_ready 1, wr_en 0, wr_ptr 63, wr_data 0, tap_idx 0, band_sel 0, mac_clr 0, mac_en 0, band_done 0, busy 0, overrun 0.
- IDLE: sample_ready=1. On sample_valid&&sample_ready: wr_data<=sample_in, wr_ptr<=wr_ptr+1 (mod 64, 63 wraps to 0), go WRITE.
- WRITE (1 cycle): wr_en=1, sample_ready=0, busy=1, tap_idx=0, band_sel=0; go RUN.
- RUN: mac_en=1; mac_clr=1 only when tap_idx==0. tap_idx increments each cycle. After tap_idx==63, go DRAIN.
- DRAIN (1 cycle): mac_en=0, band_done=1, band_sel=current band. If band_sel==NUM_BANDS−1, go IDLE. Otherwise band_sel+1, tap_idx=0, go RUN.
- Sample data is not modified. wr_ptr holds between samples. smp_addr wraps mod 64, e.g. wr_ptr=2, tap_idx=5 → 61.
- sample_valid while not IDLE: not accepted (sample_ready=0); producer must hold.
- rst in any state: next cycle all registers at reset values, including wr_ptr=63. Delay-line contents are not cleared.

## Timing
- Handshake cycle A. Cycle A+1: wr_en=1.
- Band b: RUN cycles A+2+65b .. A+65+65b; band_done at A+66+65b.
- Band 7 band_done at A+521. sample_ready=1 again at A+522. Minimum sample period 522 cycles.
- Earliest next accept is at A+522.
- mac_clr/mac_en/tap_idx/smp_addr are cycle-aligned; datapath read/multiply pipeline latency is the datapath's responsibility.

## Configuration
- Macro EQ_SCHED_OVERRUN_EN.
- Defined: overrun register sets when sample_valid=1 and state≠IDLE. It stays set until rst.
- Undefined: overrun is tied to 0 and no register is synthesized. Port is present in both builds.

## Test plan
- Reset then single sample 0x1234 at cycle A → wr_en at A+1 with wr_ptr=0, wr_data=0x1234; mac_clr at A+2; band_done with band_sel=0 at A+66; band_sel=7 at A+521; sample_ready=1 at A+522.
- Each band in a run → exactly 64 mac_en cycles, one mac_clr, tap_idx 0..63. Totals per sample: 512 mac_en, 8 band_done.
- 65 back-to-back samples (valid held high) → wr_ptr runs 0..63 then 0; smp_addr at wr_ptr=0, tap_idx=1 is 63; accept spacing exactly 522 cycles.
- rst asserted at A+100 (mid band 1) → next cycle all outputs at reset values; a new sample is then accepted with wr_ptr=0.
- With EQ_SCHED_OVERRUN_EN: valid pulse at A+10 → overrun=1 from A+11 and stays until rst. Without the macro → overrun stays 0.

Source files
------------

// File: rtl/eq_band_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eq_band_scheduler: per-sample delay-line write and 8-band x 64-tap MAC     |
// | sequencer. Optional macro EQ_SCHED_OVERRUN_EN adds a sticky overrun flag.  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module eq_band_scheduler #(
   parameter int NUM_BANDS = 8,
   parameter int TAP_BITS  = 6,
   parameter int DATA_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   sample_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                wr_en,
   output logic [TAP_BITS-1:0] wr_ptr,
   output logic [DATA_W-1:0]   wr_data,
   output logic [TAP_BITS-1:0] tap_idx,
   output logic [TAP_BITS-1:0] smp_addr,
   output logic [2:0]          band_sel,
   output logic                mac_clr,
   output logic                mac_en,
   output logic                band_done,
   output logic                busy,
   output logic                overrun
);
   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_WRITE = 2'd1;
   localparam logic [1:0] c_RUN   = 2'd2;
   localparam logic [1:0] c_DRAIN = 2'd3;

   localparam logic [2:0]          c_LAST_BAND = 3'(NUM_BANDS - 1);
   localparam logic [TAP_BITS-1:0] c_LAST_TAP  = {TAP_BITS{1'b1}};

   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic                w_accept;
   logic                w_ready_nxt;
   logic                w_wr_en_nxt;
   logic                w_busy_nxt;
   logic                w_mac_en_nxt;
   logic                w_mac_clr_nxt;
   logic                w_done_nxt;
   logic [TAP_BITS-1:0] w_tap_nxt;
   logic [2:0]          w_band_nxt;

   // sample_ready is high exactly in IDLE, so it doubles as the state gate here
   assign w_accept = sample_valid && sample_ready;
   assign smp_addr = wr_ptr - tap_idx;

   always_ff @(posedge clk) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_accept) w_state_nxt = c_WRITE;
         c_WRITE: w_state_nxt = c_RUN;
         c_RUN:   if (tap_idx == c_LAST_TAP) w_state_nxt = c_DRAIN;
         c_DRAIN: w_state_nxt = (band_sel == c_LAST_BAND) ? c_IDLE : c_RUN;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Outputs are registered, so decode them from the state being entered
   always_comb begin
      w_ready_nxt  = (w_state_nxt == c_IDLE);
      w_wr_en_nxt  = (w_state_nxt == c_WRITE);
      w_busy_nxt   = (w_state_nxt != c_IDLE);
      w_mac_en_nxt = (w_state_nxt == c_RUN);
      w_done_nxt   = (w_state_nxt == c_DRAIN);
      w_tap_nxt    = tap_idx;
      w_band_nxt   = band_sel;
      case (r_state)
         c_IDLE: begin
            if (w_accept) begin
               w_tap_nxt  = '0;
               w_band_nxt = 3'd0;
            end
         end
         c_RUN:   w_tap_nxt = tap_idx + 1'b1;
         c_DRAIN: begin
            w_tap_nxt = '0;
            if (w_state_nxt == c_RUN) w_band_nxt = band_sel + 3'd1;
         end
         default: ;
      endcase
      w_mac_clr_nxt = (w_state_nxt == c_RUN) && (w_tap_nxt == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_ready <= 1'b1;
         wr_en        <= 1'b0;
         wr_ptr       <= c_LAST_TAP;
         wr_data      <= '0;
         tap_idx      <= '0;
         band_sel     <= 3'd0;
         mac_clr      <= 1'b0;
         mac_en       <= 1'b0;
         band_done    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         sample_ready <= w_ready_nxt;
         wr_en        <= w_wr_en_nxt;
         tap_idx      <= w_tap_nxt;
         band_sel     <= w_band_nxt;
         mac_clr      <= w_mac_clr_nxt;
         mac_en       <= w_mac_en_nxt;
         band_done    <= w_done_nxt;
         busy         <= w_busy_nxt;
         if (w_accept) begin
            wr_data <= sample_in;
            wr_ptr  <= wr_ptr + 1'b1;
         end
      end
   end

`ifdef EQ_SCHED_OVERRUN_EN
   always_ff @(posedge clk) begin
      if (rst)                                    overrun <= 1'b0;
      else if (sample_valid && r_state != c_IDLE) overrun <= 1'b1;
   end
`else
   assign overrun = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eq_band_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_eq_band_scheduler: directed self-checking bench for eq_band_scheduler.  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_eq_band_scheduler;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sample_in;
   logic        sample_valid;
   logic        sample_ready;
   logic        wr_en;
   logic [5:0]  wr_ptr;
   logic [15:0] wr_data;
   logic [5:0]  tap_idx;
   logic [5:0]  smp_addr;
   logic [2:0]  band_sel;
   logic        mac_clr;
   logic        mac_en;
   logic        band_done;
   logic        busy;
   logic        overrun;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

`ifdef EQ_SCHED_OVERRUN_EN
   localparam logic c_OVR_EXP = 1'b1;
`else
   localparam logic c_OVR_EXP = 1'b0;
`endif

   eq_band_scheduler #(.NUM_BANDS(8), .TAP_BITS(6), .DATA_W(16)) dut (
      .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .wr_en(wr_en), .wr_ptr(wr_ptr), .wr_data(wr_data),
      .tap_idx(tap_idx), .smp_addr(smp_addr), .band_sel(band_sel), .mac_clr(mac_clr),
      .mac_en(mac_en), .band_done(band_done), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // {ready,wr_en,wr_ptr,wr_data,tap,band,clr,en,done,busy,overrun,smp_addr}
   task automatic check_reset(input string tag);
      check(tag, {sample_ready, wr_en, wr_ptr, wr_data, tap_idx, band_sel, mac_clr,
                  mac_en, band_done, busy, overrun, smp_addr},
                 {1'b1, 1'b0, 6'd63, 16'h0000, 6'd0, 3'd0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 6'd63});
   endtask

   task automatic wait_ready(input string tag);
      int w = 0;
      while (sample_ready !== 1'b1) begin
         @(negedge clk);
         w++;
         if (w > 600) begin
            errors++;
            $display("FAIL %s: sample_ready timeout after %0d cycles", tag, w);
            $fatal(1, "timeout");
         end
      end
   endtask

   initial begin
      logic [14:0] ov, ev;
      int t, b, n_en, n_clr, n_done, prev_acc;

      rst = 1'b1; sample_valid = 1'b0; sample_in = 16'h0000;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;

      // Single sample 0x1234, handshake cycle A
      @(negedge clk);
      check("ready_idle", sample_ready, 1'b1);
      sample_in = 16'h1234; sample_valid = 1'b1;
      n_en = 0; n_clr = 0; n_done = 0;
      @(negedge clk);
      sample_valid = 1'b0;
      for (int c = 1; c <= 522; c++) begin
         if (c > 1) @(negedge clk);
         if (c == 11) sample_valid = 1'b0;
         if (c == 1) ev = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 6'd0};
         else if (c <= 521) begin
            t = (c - 2) % 65;
            b = (c - 2) / 65;
            if (t < 64) ev = {1'b0, 1'b0, 1'b1, 1'b1, (t == 0), 1'b0, 3'(b), 6'(t)};
            else        ev = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'(b), 6'd0};
         end else ev = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 6'd0};
         ov = {sample_ready, wr_en, busy, mac_en, mac_clr, band_done,
               (c == 522) ? 3'd0 : band_sel, (c == 522) ? 6'd0 : tap_idx};
         check($sformatf("seq c=%0d", c), ov, ev);
         n_en   += int'(mac_en);
         n_clr  += int'(mac_clr);
         n_done += int'(band_done);
         if (c == 1)   check("first_wr", {wr_ptr, wr_data}, {6'd0, 16'h1234});
         if (c == 3)   check("smp_addr_wrap0", smp_addr, 6'd63);
         if (c == 11)  check("overrun_set", overrun, c_OVR_EXP);
         if (c == 522) check("overrun_hold", overrun, c_OVR_EXP);
         if (c == 10)  sample_valid = 1'b1;
      end
      check("mac_en_total", n_en, 512);
      check("mac_clr_total", n_clr, 8);
      check("band_done_total", n_done, 8);

      // Second sample, then reset mid band 1 at A2+100
      sample_in = 16'hBEEF; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      check("second_wr", {wr_en, wr_ptr, wr_data}, {1'b1, 6'd1, 16'hBEEF});
      repeat (99) @(negedge clk);
      check("mid_band1", {mac_en, band_sel}, {1'b1, 3'd1});
      rst = 1'b1;
      @(negedge clk);
      check_reset("midrun_reset");
      rst = 1'b0;

      // 65 back-to-back samples with valid held high
      sample_valid = 1'b1;
      prev_acc = 0;
      for (int k = 0; k < 65; k++) begin
         wait_ready($sformatf("b2b k=%0d", k));
         sample_in = 16'h5000 + 16'(k);
         if (k > 0) check($sformatf("spacing k=%0d", k), cyc - prev_acc, 522);
         prev_acc = cyc;
         @(negedge clk);
         check($sformatf("b2b_wr k=%0d", k), {wr_en, wr_ptr, wr_data},
               {1'b1, 6'(k), 16'h5000 + 16'(k)});
         if (k == 2) begin
            repeat (6) @(negedge clk);
            check("smp_addr_2_5", {tap_idx, smp_addr}, {6'd5, 6'd61});
         end
         if (k == 64) begin
            repeat (2) @(negedge clk);
            check("smp_addr_0_1", {tap_idx, smp_addr}, {6'd1, 6'd63});
            sample_valid = 1'b0;
         end
      end
      wait_ready("final_idle");
      check("final_idle", {busy, overrun}, {1'b0, c_OVR_EXP});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset("final_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
